// File: rtl/fft_addr_gen.sv
// fft_addr_gen: sample-load, butterfly read/write and twiddle address
// generator for a radix-2 in-place FFT. It also returns the completion flags
// that the FFT control FSM branches on.
// Build option: FFT_BITREV_EN selects a bit-reversed sample load address.
// Without it, the load address is the natural sample count.

module fft_addr_gen #(
    parameter  int unsigned N_POINTS = 16,
    localparam int unsigned ADDR_W   = $clog2(N_POINTS),
    localparam int unsigned STG_W    = (ADDR_W > 1) ? $clog2(ADDR_W) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              en_cnt_samples_i,
    input  logic              en_cnt_rd_i,
    input  logic              wr_mem_i,
    output logic [ADDR_W-1:0] sample_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-2:0] twiddle_idx_o,
    output logic [STG_W-1:0]  stage_o,
    output logic [ADDR_W-2:0] bfly_o,
    output logic              end_samples_o,
    output logic              end_read_1_o,
    output logic              end_read_2_o,
    output logic              end_write_1_o,
    output logic              end_algo_o
);

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(ADDR_W - 1);

    logic [ADDR_W-1:0] cs;
    logic              rp;
    logic              wp;
    logic [ADDR_W-2:0] b;
    logic [STG_W-1:0]  s;

    logic              wr_stb;
    logic              last_bfly;
    logic              last_stg;
    logic [ADDR_W-1:0] b_ext;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;

    // A write is only a butterfly write while no sample is being loaded.
    assign wr_stb    = wr_mem_i & ~en_cnt_samples_i;
    assign last_bfly = &b;
    assign last_stg  = (s == LAST_STG);

    // Butterfly operand addresses for butterfly b of stage s.
    // The shift by s+1 is split into two shifts so s+1 cannot overflow STG_W.
    always_comb begin
        b_ext  = {1'b0, b};
        span   = ADDR_W'(1) << s;
        pos    = b_ext & (span - ADDR_W'(1));
        addr_a = (((b_ext >> s) << 1) << s) | pos;
        addr_b = addr_a + span;
    end

    assign twiddle_idx_o = pos[ADDR_W-2:0] << (LAST_STG - s);
    assign rd_addr_o     = rp ? addr_b : addr_a;
    assign wr_addr_o     = wp ? addr_b : addr_a;
    assign stage_o       = s;
    assign bfly_o        = b;

`ifdef FFT_BITREV_EN
    // The load address is the bit-reversed sample count, which gives a
    // natural-order output from the decimation-in-time transform.
    always_comb begin
        sample_addr_o = '0;
        for (int unsigned i = 0; i < ADDR_W; i++) begin
            sample_addr_o[i] = cs[ADDR_W-1-i];
        end
    end
`else
    // The load address is the natural sample count. Upstream supplies the
    // samples already in bit-reversed order.
    always_comb begin
        sample_addr_o = cs;
    end
`endif

    // Completion flags are combinational with the accepted strobe and are
    // suppressed by clear_i.
    always_comb begin
        end_samples_o = ~clear_i & en_cnt_samples_i & (&cs);
        end_read_1_o  = ~clear_i & en_cnt_rd_i & ~rp;
        end_read_2_o  = ~clear_i & en_cnt_rd_i & rp;
        end_write_1_o = ~clear_i & wr_stb & ~wp;
        end_algo_o    = ~clear_i & wr_stb & wp & last_bfly & last_stg;
    end

    // Counter and phase state. clear_i takes priority over every strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs <= '0;
            rp <= 1'b0;
            wp <= 1'b0;
            b  <= '0;
            s  <= '0;
        end else if (clear_i) begin
            cs <= '0;
            rp <= 1'b0;
            wp <= 1'b0;
            b  <= '0;
            s  <= '0;
        end else begin
            if (en_cnt_samples_i) begin
                cs <= cs + ADDR_W'(1);
            end
            if (en_cnt_rd_i) begin
                rp <= ~rp;
            end
            if (wr_stb) begin
                wp <= ~wp;
                if (wp) begin
                    if (!last_bfly) begin
                        b <= b + 1'b1;
                    end else begin
                        b <= '0;
                        s <= last_stg ? '0 : s + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: directed bench for fft_addr_gen at N_POINTS=8.
// Expected sample-load order follows FFT_BITREV_EN, when it is defined.

module tb_fft_addr_gen;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clear_i;
    logic       en_cnt_samples_i;
    logic       en_cnt_rd_i;
    logic       wr_mem_i;
    logic [2:0] sample_addr_o;
    logic [2:0] rd_addr_o;
    logic [2:0] wr_addr_o;
    logic [1:0] twiddle_idx_o;
    logic [1:0] stage_o;
    logic [1:0] bfly_o;
    logic       end_samples_o;
    logic       end_read_1_o;
    logic       end_read_2_o;
    logic       end_write_1_o;
    logic       end_algo_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    fft_addr_gen #(.N_POINTS(8)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .en_cnt_samples_i (en_cnt_samples_i),
        .en_cnt_rd_i      (en_cnt_rd_i),
        .wr_mem_i         (wr_mem_i),
        .sample_addr_o    (sample_addr_o),
        .rd_addr_o        (rd_addr_o),
        .wr_addr_o        (wr_addr_o),
        .twiddle_idx_o    (twiddle_idx_o),
        .stage_o          (stage_o),
        .bfly_o           (bfly_o),
        .end_samples_o    (end_samples_o),
        .end_read_1_o     (end_read_1_o),
        .end_read_2_o     (end_read_2_o),
        .end_write_1_o    (end_write_1_o),
        .end_algo_o       (end_algo_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one cycle of strobes at the falling edge; the caller checks the
    // combinational flags right after, and registered effects appear after
    // the next rising edge.
    task automatic cyc(input logic smp, input logic rd, input logic wr, input logic clr);
        @(negedge clk_i);
        en_cnt_samples_i = smp;
        en_cnt_rd_i      = rd;
        wr_mem_i         = wr;
        clear_i          = clr;
        #1;
    endtask

    logic [4:0] ends;
    assign ends = {end_samples_o, end_read_1_o, end_read_2_o, end_write_1_o, end_algo_o};

    logic [2:0] exp_samp [8];
    logic [2:0] exp_wr   [24];
    logic [1:0] exp_tw   [12];

    initial begin
`ifdef FFT_BITREV_EN
        exp_samp = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
        exp_samp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
        exp_wr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                   3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                   3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};
        exp_tw = '{2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd2, 2'd0, 2'd2,
                   2'd0, 2'd1, 2'd2, 2'd3};

        rst_ni = 1'b0;
        clear_i = 1'b0;
        en_cnt_samples_i = 1'b0;
        en_cnt_rd_i = 1'b0;
        wr_mem_i = 1'b0;
        #1;
        chk("reset_sample_addr", sample_addr_o, 0);
        chk("reset_rd_addr", rd_addr_o, 0);
        chk("reset_wr_addr", wr_addr_o, 0);
        chk("reset_twiddle", twiddle_idx_o, 0);
        chk("reset_stage", stage_o, 0);
        chk("reset_bfly", bfly_o, 0);
        chk("reset_ends", ends, 0);

        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("idle_ends", ends, 0);
        end

        // Sample load with the write strobe held high; no butterfly writes.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("load_addr_%0d", i), sample_addr_o, exp_samp[i]);
            chk($sformatf("load_end_%0d", i), end_samples_o, (i == 7) ? 1 : 0);
            chk($sformatf("load_wr1_%0d", i), end_write_1_o, 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("load_wrap_addr", sample_addr_o, 0);
        chk("load_bfly", bfly_o, 0);
        chk("load_stage", stage_o, 0);

        // Full transform: each write coincides with a read, so both phase
        // bits move together and the read address tracks the write address.
        for (int w = 0; w < 24; w++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("xf_stage_%0d", w + 1), stage_o, w / 8);
            chk($sformatf("xf_bfly_%0d", w + 1), bfly_o, (w / 2) % 4);
            chk($sformatf("xf_wr_addr_%0d", w + 1), wr_addr_o, exp_wr[w]);
            chk($sformatf("xf_rd_addr_%0d", w + 1), rd_addr_o, exp_wr[w]);
            chk($sformatf("xf_twiddle_%0d", w + 1), twiddle_idx_o, exp_tw[w / 2]);
            chk($sformatf("xf_wr1_%0d", w + 1), end_write_1_o, (w % 2 == 0) ? 1 : 0);
            chk($sformatf("xf_rd1_%0d", w + 1), end_read_1_o, (w % 2 == 0) ? 1 : 0);
            chk($sformatf("xf_rd2_%0d", w + 1), end_read_2_o, (w % 2 == 1) ? 1 : 0);
            chk($sformatf("xf_algo_%0d", w + 1), end_algo_o, (w == 23) ? 1 : 0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("xf_done_stage", stage_o, 0);
        chk("xf_done_bfly", bfly_o, 0);
        chk("xf_done_wr_addr", wr_addr_o, 0);
        chk("xf_done_rd_addr", rd_addr_o, 0);
        chk("xf_done_ends", ends, 0);

        // Asynchronous reset in the middle of stage 1, butterfly 3.
        for (int w = 0; w < 14; w++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_bfly", bfly_o, 3);
        chk("mid_stage", stage_o, 1);
        chk("mid_wr_addr", wr_addr_o, 5);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_bfly", bfly_o, 0);
        chk("async_rst_stage", stage_o, 0);
        chk("async_rst_wr_addr", wr_addr_o, 0);
        chk("async_rst_twiddle", twiddle_idx_o, 0);
        chk("async_rst_ends", ends, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ends", ends, 0);

        // Clear at b=2 with both phase bits set and both strobes active.
        for (int w = 0; w < 5; w++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_clr_bfly", bfly_o, 2);
        chk("pre_clr_wr_addr", wr_addr_o, 5);
        chk("pre_clr_rd_addr", rd_addr_o, 5);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_ends", ends, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_clr_bfly", bfly_o, 0);
        chk("post_clr_stage", stage_o, 0);
        chk("post_clr_rd_addr", rd_addr_o, 0);
        chk("post_clr_wr_addr", wr_addr_o, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("post_clr_rd1", end_read_1_o, 1);
        chk("post_clr_wr1", end_write_1_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_addr_gen.md
# fft_addr_gen

Address and sequence generator for the radix-2 in-place FFT core. It acts as the counter/datapath-side responder to the FFT control FSM. It consumes the FSM's enable strobes (sample count, read count, memory write) and returns the completion flags the FSM branches on: `end_samples`, `end_read_1/2`, `end_write_1` and `end_algo`. It also drives the sample-load, butterfly-read, butterfly-write and twiddle-index addresses into the sample RAM and twiddle ROM.

## Interface
Parameters:
- `N_POINTS`, 16: FFT size; power of two, >= 4.
- `ADDR_W`, `$clog2(N_POINTS)`: sample address width; localparam, derived.
- `STG_W`, `max(1,$clog2(ADDR_W))`: stage counter width; localparam, derived.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous clear of all counters; priority over every enable.
- `en_cnt_samples_i`  in  1  sample-load strobe, one sample per cycle.
- `en_cnt_rd_i`  in  1  butterfly operand read strobe.
- `wr_mem_i`  in  1  memory write strobe; counted as a butterfly write only when `en_cnt_samples_i`=0.
- `sample_addr_o`  out  ADDR_W  RAM write address for the sample being loaded.
- `rd_addr_o`  out  ADDR_W  butterfly read address.
- `wr_addr_o`  out  ADDR_W  butterfly write-back address.
- `twiddle_idx_o`  out  ADDR_W-1  twiddle ROM index for the current butterfly.
- `stage_o`  out  STG_W  current stage s, 0..L-1, where L=ADDR_W.
- `bfly_o`  out  ADDR_W-1  current butterfly index b, 0..N/2-1.
- `end_samples_o`  out  1  last sample being loaded.
- `end_read_1_o`  out  1  first-operand read accepted.
- `end_read_2_o`  out  1  second-operand read accepted.
- `end_write_1_o`  out  1  first-operand write accepted.
- `end_algo_o`  out  1  final write of the final stage accepted.

## Operation

**State registers**
- Sample counter `cs` (ADDR_W bits).
- Read phase bit `rp` and write phase bit `wp`.
- Butterfly counter `b` and stage counter `s`.

**Address arithmetic**, combinational from `b` and `s`:
- `span` = 1<<s
- `pos` = b & (span-1)
- `A` = ((b>>s)<<(s+1)) | pos
- `B` = A + span
- `twiddle_idx_o` = pos << (L-1-s)
- All results are truncated to the port width.

**Sample load**
- `en_cnt_samples_i`=1: `cs` increments and wraps N-1→0.
- `sample_addr_o` = f(`cs`); f is set by the Configuration macro.
- `end_samples_o` = `en_cnt_samples_i` & (`cs`==N-1).

**Read**
- `rd_addr_o` = `rp` ? B : A.
- `en_cnt_rd_i`=1 toggles `rp`.
- `end_read_1_o` = `en_cnt_rd_i` & !`rp`.
- `end_read_2_o` = `en_cnt_rd_i` & `rp`.

**Write**
- Write strobe w = `wr_mem_i` & !`en_cnt_samples_i`.
- `wr_addr_o` = `wp` ? B : A.
- w toggles `wp`.
- `end_write_1_o` = w & !`wp`.

**Advance**, on w & `wp` (second write of a butterfly):
- b < N/2-1: b++.
- Otherwise b←0.
- If in addition s < L-1: s++.
- Otherwise (last butterfly of the last stage): `end_algo_o`=1 and s←0. All counters return to the reset state on that edge.

**Other rules**
- Reads and writes share `b`/`s`. Read strobes never advance `b`.
- Read and write strobes may coincide; each phase bit updates independently.
- `clear_i`=1 zeroes `cs`, `rp`, `wp`, `b` and `s`, and forces all `end_*` outputs to 0 in that cycle.

## Timing
- **Reset values:** all counters and phase bits 0. Hence `rd_addr_o`=`wr_addr_o`=`twiddle_idx_o`=`stage_o`=`bfly_o`=0 and `sample_addr_o`=0.
- **`end_*` outputs:** combinational, 0 whenever their strobe is low. They are valid in the same cycle as the accepted strobe, so the FSM samples them on the edge at which the counter advances.
- **Addresses:** combinational from registers, updated one cycle after the accepted strobe.
- **Reset mid-operation:** asynchronous return to reset values. There is no memory of a partial butterfly.
- **Total write count:** a full transform needs exactly L·N write strobes; `end_algo_o` is on the last one. N=16 gives 64.

## Configuration
- **`FFT_BITREV_EN` defined:** `sample_addr_o` = bit-reverse(`cs`) over ADDR_W bits. The input is loaded in bit-reversed order for decimation-in-time, and output is natural order.
- **`FFT_BITREV_EN` undefined:** `sample_addr_o` = `cs`. The upstream block supplies pre-reversed samples.
- The macro changes nothing else.

## Test plan
- **Reset and idle:** assert `rst_ni`=0 mid-run with b=3, s=1 → all outputs 0 immediately. After release, with strobes low, all `end_*` stay 0.
- **Sample load, N=8, `FFT_BITREV_EN` defined:** 8 consecutive `en_cnt_samples_i` → `sample_addr_o` sequence 0,4,2,6,1,5,3,7. `end_samples_o` only on the 8th. With `wr_mem_i` high throughout, `b` stays 0.
- **Sample load, macro undefined:** the same stimulus gives the sequence 0..7.
- **Address map, N=8:**
  - s=0, b=0 → A=0, B=1, twiddle 0.
  - s=1, b=1 → A=1, B=3, twiddle 2.
  - s=2, b=3 → A=3, B=7, twiddle 3.
  - Read pairs pulse `end_read_1_o` then `end_read_2_o`.
- **Full transform, N=8:** 24 butterfly write strobes → `end_write_1_o` on every odd strobe, `stage_o` increments after writes 8 and 16, `end_algo_o` only on write 24, then all counters are 0.
- **`clear_i` priority:** `clear_i`=1 together with `en_cnt_rd_i` and `wr_mem_i` at b=2 → no `end_*` pulse, and next cycle b=0, s=0, `rp`=`wp`=0.
